// File: rtl/ahb_dec_pkg.sv
// rtl/ahb_dec_pkg.sv - shared encodings, slot indices and FSM states for the AHB slave decoder
package ahb_dec_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [1:0] SLV_S0 = 2'd0;
    localparam logic [1:0] SLV_S1 = 2'd1;
    localparam logic [1:0] SLV_S2 = 2'd2;
    localparam logic [1:0] SLV_S3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TOERR1,
        TOERR2
    } dec_state_t;

    function automatic logic is_xfer(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_slv_dec_if.sv
// rtl/ahb_slv_dec_if.sv - AHB-Lite bus bundle between master, decoder and slots s0-s3
interface ahb_slv_dec_if;

    logic [31:0] haddr;
    logic [1:0]  htrans;

    logic        hsel_s0;
    logic        hsel_s1;
    logic        hsel_s2;
    logic        hsel_s3;

    logic [31:0] hrdata_s0;
    logic [31:0] hrdata_s1;
    logic [31:0] hrdata_s2;
    logic [31:0] hrdata_s3;
    logic        hready_s0;
    logic        hready_s1;
    logic        hready_s2;
    logic        hready_s3;
    logic [1:0]  hresp_s0;
    logic [1:0]  hresp_s1;
    logic [1:0]  hresp_s2;
    logic [1:0]  hresp_s3;

    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;

    modport slave (
        input  haddr, htrans,
        input  hrdata_s0, hrdata_s1, hrdata_s2, hrdata_s3,
        input  hready_s0, hready_s1, hready_s2, hready_s3,
        input  hresp_s0, hresp_s1, hresp_s2, hresp_s3,
        output hsel_s0, hsel_s1, hsel_s2, hsel_s3,
        output hrdata, hready, hresp
    );

    modport master (
        output haddr, htrans,
        output hrdata_s0, hrdata_s1, hrdata_s2, hrdata_s3,
        output hready_s0, hready_s1, hready_s2, hready_s3,
        output hresp_s0, hresp_s1, hresp_s2, hresp_s3,
        input  hsel_s0, hsel_s1, hsel_s2, hsel_s3,
        input  hrdata, hready, hresp
    );

endinterface

// File: rtl/ahb_dec_wdog.sv
// rtl/ahb_dec_wdog.sv - data-phase wait counter; expire marks the last tolerated wait cycle
module ahb_dec_wdog #(
    parameter int TIMEOUT = 256
) (
    input  logic pll_core_cpuclk,
    input  logic pad_cpu_rst_b,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Only a wait cycle can expire, so a slave raising hready at the limit wins.
    assign expire = inc && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ahb_slv_dec.sv
// rtl/ahb_slv_dec.sv - AHB-Lite address decoder, response mux and data-phase watchdog
module ahb_slv_dec
    import ahb_dec_pkg::*;
#(
    parameter int         TIMEOUT   = 256,
    parameter logic [3:0] S0_REGION = 4'h0,
    parameter logic [3:0] S1_REGION = 4'h2,
    parameter logic [3:0] S2_REGION = 4'h4
) (
    input  logic         pll_core_cpuclk,
    input  logic         pad_cpu_rst_b,
    ahb_slv_dec_if.slave bus,
    output logic         timeout_irq,
    output logic [1:0]   timeout_slv
);

    dec_state_t  state;
    dec_state_t  state_nxt;
    logic [1:0]  dec_idx;
    logic [1:0]  dsel;
    logic        dact;
    logic        xfer;

    logic [31:0] s_rdata;
    logic        s_ready;
    logic [1:0]  s_resp;

    logic [31:0] hrdata_int;
    logic        hready_int;
    logic [1:0]  hresp_int;

    logic        wd_clr;
    logic        wd_inc;
    logic        wd_expire;

    logic        unused_haddr;

    assign unused_haddr = ^bus.haddr[27:0];
    assign xfer         = is_xfer(bus.htrans);

    always_comb begin
        dec_idx = SLV_S3;
        if (bus.haddr[31:28] == S0_REGION) begin
            dec_idx = SLV_S0;
        end else if (bus.haddr[31:28] == S1_REGION) begin
            dec_idx = SLV_S1;
        end else if (bus.haddr[31:28] == S2_REGION) begin
            dec_idx = SLV_S2;
        end
    end

    assign bus.hsel_s0 = (dec_idx == SLV_S0);
    assign bus.hsel_s1 = (dec_idx == SLV_S1);
    assign bus.hsel_s2 = (dec_idx == SLV_S2);
    assign bus.hsel_s3 = (dec_idx == SLV_S3);

    // Response select follows the registered data-phase owner, never haddr.
    always_comb begin
        s_rdata = bus.hrdata_s0;
        s_ready = bus.hready_s0;
        s_resp  = bus.hresp_s0;
        case (dsel)
            SLV_S1: begin
                s_rdata = bus.hrdata_s1;
                s_ready = bus.hready_s1;
                s_resp  = bus.hresp_s1;
            end
            SLV_S2: begin
                s_rdata = bus.hrdata_s2;
                s_ready = bus.hready_s2;
                s_resp  = bus.hresp_s2;
            end
            SLV_S3: begin
                s_rdata = bus.hrdata_s3;
                s_ready = bus.hready_s3;
                s_resp  = bus.hresp_s3;
            end
            default: ;
        endcase
    end

    assign wd_inc = (state == DATA) && dact && !s_ready;
    assign wd_clr = (state != DATA) || s_ready;

    ahb_dec_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .clr             (wd_clr),
        .inc             (wd_inc),
        .expire          (wd_expire)
    );

    always_comb begin
        state_nxt   = state;
        hready_int  = 1'b1;
        hresp_int   = HRESP_OKAY;
        hrdata_int  = '0;
        timeout_irq = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) state_nxt = DATA;
            end
            DATA: begin
                hready_int = s_ready;
                hresp_int  = s_resp;
                hrdata_int = s_rdata;
                if (s_ready) begin
                    state_nxt = xfer ? DATA : IDLE;
                end else if (wd_expire) begin
                    state_nxt = TOERR1;
                end
            end
            TOERR1: begin
                hready_int  = 1'b0;
                hresp_int   = HRESP_ERROR;
                timeout_irq = 1'b1;
                state_nxt   = TOERR2;
            end
            TOERR2: begin
                hresp_int = HRESP_ERROR;
                state_nxt = xfer ? DATA : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.hready = hready_int;
    assign bus.hresp  = hresp_int;
    assign bus.hrdata = hrdata_int;

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state       <= IDLE;
            dsel        <= SLV_S0;
            dact        <= 1'b0;
            timeout_slv <= SLV_S0;
        end else begin
            state <= state_nxt;
            if (hready_int) begin
                dsel <= dec_idx;
                dact <= xfer;
            end
            if (state == TOERR1) begin
                timeout_slv <= dsel;
            end
        end
    end

endmodule

// File: tb/tb_ahb_slv_dec.sv
// tb/tb_ahb_slv_dec.sv - scoreboard bench for ahb_slv_dec with TIMEOUT=4
module tb_ahb_slv_dec;

    logic pll_core_cpuclk;
    logic pad_cpu_rst_b;
    logic timeout_irq;
    logic [1:0] timeout_slv;

    ahb_slv_dec_if bus ();

    ahb_slv_dec #(
        .TIMEOUT (4)
    ) dut (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .bus             (bus),
        .timeout_irq     (timeout_irq),
        .timeout_slv     (timeout_slv)
    );

    initial pll_core_cpuclk = 1'b0;
    always #5 pll_core_cpuclk = ~pll_core_cpuclk;

    typedef struct packed {
        logic [3:0]  hsel;
        logic        hready;
        logic [1:0]  hresp;
        logic [31:0] hrdata;
        logic        irq;
        logic [1:0]  tslv;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_hsel(input logic [31:0] addr);
        case (addr[31:28])
            4'h0:    return 4'b0001;
            4'h2:    return 4'b0010;
            4'h4:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic tick();
        @(posedge pll_core_cpuclk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic rdy, input logic [1:0] resp,
                              input logic [31:0] rdata, input logic irq, input logic [1:0] tslv);
        exp_t e;
        e.hsel   = exp_hsel(bus.haddr);
        e.hready = rdy;
        e.hresp  = resp;
        e.hrdata = rdata;
        e.irq    = irq;
        e.tslv   = tslv;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    always @(negedge pll_core_cpuclk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".hsel"},   32'({bus.hsel_s3, bus.hsel_s2, bus.hsel_s1, bus.hsel_s0}), 32'(e.hsel));
            chk({t, ".hready"}, 32'(bus.hready), 32'(e.hready));
            chk({t, ".hresp"},  32'(bus.hresp),  32'(e.hresp));
            chk({t, ".hrdata"}, bus.hrdata,      e.hrdata);
            chk({t, ".irq"},    32'(timeout_irq), 32'(e.irq));
            chk({t, ".tslv"},   32'(timeout_slv), 32'(e.tslv));
        end
    end

    initial begin
        pad_cpu_rst_b  = 1'b0;
        bus.haddr      = 32'h0;
        bus.htrans     = 2'b00;
        bus.hrdata_s0  = 32'hDEAD_BEEF;
        bus.hrdata_s1  = 32'h1111_1111;
        bus.hrdata_s2  = 32'h2222_2222;
        bus.hrdata_s3  = 32'h3333_3333;
        bus.hready_s0  = 1'b1;
        bus.hready_s1  = 1'b1;
        bus.hready_s2  = 1'b1;
        bus.hready_s3  = 1'b1;
        bus.hresp_s0   = 2'b00;
        bus.hresp_s1   = 2'b00;
        bus.hresp_s2   = 2'b00;
        bus.hresp_s3   = 2'b00;

        // reset and idle decode
        tick(); expect_out("rst_hold", 1, 2'b00, 0, 0, 0);
        tick(); pad_cpu_rst_b = 1'b1; expect_out("rst_rel", 1, 2'b00, 0, 0, 0);
        tick(); bus.haddr = 32'h2000_0000; expect_out("idle_s1", 1, 2'b00, 0, 0, 0);
        tick(); bus.haddr = 32'h9000_0000; expect_out("idle_s3", 1, 2'b00, 0, 0, 0);

        // single read from s0
        tick(); bus.haddr = 32'h0000_0010; bus.htrans = 2'b10; expect_out("rd0_addr", 1, 2'b00, 0, 0, 0);
        tick(); bus.haddr = 32'h9000_0000; bus.htrans = 2'b00; expect_out("rd0_data", 1, 2'b00, 32'hDEAD_BEEF, 0, 0);
        tick(); expect_out("rd0_idle", 1, 2'b00, 0, 0, 0);

        // unmapped address -> s3 error slave, two-cycle ERROR
        tick(); bus.haddr = 32'hF000_0000; bus.htrans = 2'b10; expect_out("err_addr", 1, 2'b00, 0, 0, 0);
        tick(); bus.htrans = 2'b00; bus.hready_s3 = 1'b0; bus.hresp_s3 = 2'b01;
        expect_out("err_c1", 0, 2'b01, 32'h3333_3333, 0, 0);
        tick(); bus.hready_s3 = 1'b1; expect_out("err_c2", 1, 2'b01, 32'h3333_3333, 0, 0);
        tick(); bus.hresp_s3 = 2'b00; expect_out("err_idle", 1, 2'b00, 0, 0, 0);

        // s2 stalls forever -> watchdog
        tick(); bus.haddr = 32'h4000_0000; bus.htrans = 2'b10; bus.hready_s2 = 1'b0;
        expect_out("to_addr", 1, 2'b00, 0, 0, 0);
        tick(); bus.htrans = 2'b00; expect_out("to_w1", 0, 2'b00, 32'h2222_2222, 0, 0);
        for (int i = 2; i <= 4; i++) begin
            tick(); expect_out($sformatf("to_w%0d", i), 0, 2'b00, 32'h2222_2222, 0, 0);
        end
        tick(); expect_out("to_err1", 0, 2'b01, 0, 1, 0);
        tick(); expect_out("to_err2", 1, 2'b01, 0, 0, 2);
        tick(); expect_out("to_idle", 1, 2'b00, 0, 0, 2);

        // s2 ready on the 4th wait cycle: slave wins, no timeout
        tick(); bus.htrans = 2'b10; expect_out("race_addr", 1, 2'b00, 0, 0, 2);
        tick(); bus.htrans = 2'b00; expect_out("race_w1", 0, 2'b00, 32'h2222_2222, 0, 2);
        tick(); expect_out("race_w2", 0, 2'b00, 32'h2222_2222, 0, 2);
        tick(); expect_out("race_w3", 0, 2'b00, 32'h2222_2222, 0, 2);
        tick(); bus.hready_s2 = 1'b1; expect_out("race_done", 1, 2'b00, 32'h2222_2222, 0, 2);
        tick(); expect_out("race_idle", 1, 2'b00, 0, 0, 2);

        // back-to-back s0 (2 waits) then s1
        tick(); bus.haddr = 32'h0000_0100; bus.htrans = 2'b10; expect_out("b2b_a0", 1, 2'b00, 0, 0, 2);
        tick(); bus.haddr = 32'h2000_0000; bus.hready_s0 = 1'b0;
        expect_out("b2b_w1", 0, 2'b00, 32'hDEAD_BEEF, 0, 2);
        tick(); expect_out("b2b_w2", 0, 2'b00, 32'hDEAD_BEEF, 0, 2);
        tick(); bus.hready_s0 = 1'b1; expect_out("b2b_d0", 1, 2'b00, 32'hDEAD_BEEF, 0, 2);
        tick(); bus.htrans = 2'b00; expect_out("b2b_d1", 1, 2'b00, 32'h1111_1111, 0, 2);
        tick(); expect_out("b2b_idle", 1, 2'b00, 0, 0, 2);

        // reset pulsed during TOERR1
        tick(); bus.haddr = 32'h4000_0000; bus.htrans = 2'b10; bus.hready_s2 = 1'b0;
        expect_out("rto_addr", 1, 2'b00, 0, 0, 2);
        tick(); bus.htrans = 2'b00; expect_out("rto_w1", 0, 2'b00, 32'h2222_2222, 0, 2);
        for (int i = 2; i <= 4; i++) begin
            tick(); expect_out($sformatf("rto_w%0d", i), 0, 2'b00, 32'h2222_2222, 0, 2);
        end
        tick(); expect_out("rto_err1", 0, 2'b01, 0, 1, 2);
        @(negedge pll_core_cpuclk);
        #1;
        pad_cpu_rst_b = 1'b0;
        #1;
        chk("rto_async.hready", 32'(bus.hready), 32'd1);
        chk("rto_async.hresp",  32'(bus.hresp),  32'd0);
        chk("rto_async.hrdata", bus.hrdata,      32'd0);
        chk("rto_async.irq",    32'(timeout_irq), 32'd0);
        chk("rto_async.tslv",   32'(timeout_slv), 32'd0);
        tick(); bus.hready_s2 = 1'b1; expect_out("rto_hold", 1, 2'b00, 0, 0, 0);
        tick(); pad_cpu_rst_b = 1'b1; expect_out("rto_rel", 1, 2'b00, 0, 0, 0);
        tick(); expect_out("rto_idle", 1, 2'b00, 0, 0, 0);

        tick();
        tick();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_slv_dec.md
# ahb_slv_dec

AHB-Lite slave-side decoder and response multiplexer for the smart_run SoC bus. It decodes the address phase into one-hot slave selects for slots s0–s2, and routes every unmapped address to slot s3, the error-response slave. It registers the data-phase owner and muxes that slave's hrdata/hready/hresp back to the master. A per-transfer watchdog terminates any data phase stalled beyond TIMEOUT cycles with a block-generated two-cycle ERROR response.

## Interface
- S0_REGION, 4'h0, haddr[31:28] value selecting s0
- S1_REGION, 4'h2, haddr[31:28] value selecting s1
- S2_REGION, 4'h4, haddr[31:28] value selecting s2; all other regions select s3
- TIMEOUT, 256, maximum consecutive wait cycles in one data phase; legal range ≥2
- pll_core_cpuclk  input  1  sole clock, rising edge
- pad_cpu_rst_b  input  1  reset; **one clock; reset is asynchronous and active-low**
- haddr  input  32  master address
- htrans  input  2  master transfer type; bit1=1 means NONSEQ/SEQ
- hsel_s0..hsel_s3  output  1 each  one-hot decode of haddr, combinational
- hrdata_s0..hrdata_s3  input  32 each  slave read data
- hready_s0..hready_s3  input  1 each  slave ready
- hresp_s0..hresp_s3  input  2 each  slave response
- hrdata  output  32  muxed read data to master
- hready  output  1  muxed ready to master; also fed back to all slaves
- hresp  output  2  muxed response; 2'b00 OKAY, 2'b01 ERROR
- timeout_irq  output  1  one-cycle pulse on watchdog expiry
- timeout_slv  output  2  index of the slave that last timed out, registered

## Operation
- Decode: hsel_sN = (haddr[31:28]==SN_REGION) for N=0..2; hsel_s3 = none of them. Exactly one hsel is high at all times, independent of htrans.
- Address sampled when hready=1: dsel <= decoded index and dact <= htrans[1].
- FSM states: IDLE (no active data phase), DATA, TOERR1, TOERR2.
  - IDLE: hready=1, hresp=OKAY, hrdata=0. On a sample with htrans[1]=1 → DATA; otherwise stay in IDLE.
  - DATA: outputs are the slave[dsel] signals passed through.
    - If hready_s[dsel]=1: the phase ends and the next address is sampled; go to DATA or IDLE per htrans[1].
    - Else: increment wait counter cnt. When cnt==TIMEOUT-1 with hready_s[dsel] still low → TOERR1.
  - TOERR1: hready=0, hresp=ERROR, hrdata=0; timeout_irq=1; timeout_slv<=dsel. Always → TOERR2.
  - TOERR2: hready=1, hresp=ERROR, hrdata=0. Address is sampled here → DATA or IDLE. The stalled slave is abandoned.
- cnt clears to 0 on every new sample and in IDLE/TOERR*. cnt width is $clog2(TIMEOUT)+1.
- Slave-generated ERROR, e.g. from s3 (hready low then high with hresp=01), passes through unchanged. The watchdog only acts on hready.
- Simultaneous events: if a slave asserts hready in the same cycle cnt reaches TIMEOUT-1, the slave wins. There is no timeout, and timeout_irq stays 0.

## Timing
- Decode and response muxing are zero-latency combinational. The mux select comes from registered dsel/state only, never from haddr.
- Watchdog: a data phase that sees exactly TIMEOUT consecutive cycles with hready_s[dsel]=0 enters TOERR1 on the next edge. The master then sees hready=1 exactly TIMEOUT+2 cycles after the phase starts.
- Reset values (asynchronous, immediate on pad_cpu_rst_b=0):
  - State and counters: state=IDLE, dact=0, dsel=0, cnt=0.
  - Outputs: hready=1, hresp=00, hrdata=0, timeout_irq=0, timeout_slv=0.
- Reset asserted mid-transfer, including during TOERR1: the block returns to IDLE at once and no response completes.

## Structure
- Package ahb_dec_pkg:
  - HTRANS encodings and HRESP_OKAY/HRESP_ERROR.
  - Slot index constants SLV_S0..SLV_S3.
  - State enum IDLE/DATA/TOERR1/TOERR2.
- One sub-module, ahb_dec_wdog: wait counter plus expiry compare, parameterized by TIMEOUT. It takes clr and inc inputs and produces an expire output.

## Test plan
- Reset, no traffic: hready=1, hresp=00, hrdata=0; haddr=0x2000_0000 → hsel_s1=1 only; haddr=0x9000_0000 → hsel_s3=1 only.
- NONSEQ read to 0x0000_0010 with s0 hready=1 and hrdata_s0=0xDEADBEEF → next cycle hrdata=0xDEADBEEF, hready=1, hresp=00.
- NONSEQ to 0xF000_0000 driven through the s3 error slave model → master sees a two-cycle ERROR: hready 0 then 1, with hresp=01 both cycles.
- TIMEOUT=4, s2 holds hready_s2=0 forever:
  - Expected response: 4 wait cycles, then TOERR1 (hready=0, hresp=01, timeout_irq=1), then TOERR2 (hready=1, hresp=01), with timeout_slv=2.
  - Same setup, but s2 raises hready on its 4th wait cycle → normal completion with timeout_irq=0.
- Back-to-back NONSEQ s0→s1 with s0 inserting 2 waits → s1's address is held until s0 completes; dsel switches on the completing edge and s1 data is returned one cycle later.
- pad_cpu_rst_b pulsed low during TOERR1 → outputs return to reset values immediately with no residual ERROR cycle.
